// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if
//   Groups the coin sensor lines, the accept enable and the cleaned-up coin
//   outputs so the acceptor and its user connect through one port.
//   Signals:
//     coin5_raw, coin10_raw  raw asynchronous sensor lines (high while a coin passes)
//     accept_en              1 = coins accepted, 0 = every detected coin is rejected
//     coin_code              00 none, 01 five, 10 ten (single-cycle pulses)
//     reject                 one-cycle pulse per coin returned to the chute
//     fifo_full              coin buffer occupancy equals its depth
//     overflow               sticky, a coin was rejected because the buffer was full
//   Modports: master = sensor/vending side, slave = coin_acceptor.
interface coin_acceptor_if;
   logic       coin5_raw;
   logic       coin10_raw;
   logic       accept_en;
   logic [1:0] coin_code;
   logic       reject;
   logic       fifo_full;
   logic       overflow;

   modport master (
      output coin5_raw, coin10_raw, accept_en,
      input  coin_code, reject, fifo_full, overflow
   );

   modport slave (
      input  coin5_raw, coin10_raw, accept_en,
      output coin_code, reject, fifo_full, overflow
   );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end of the vending machine. Synchronises and debounces the two raw
//   coin sensors, turns each debounced rising edge into one coin event,
//   rejects jams / disabled / overflow coins, buffers accepted coins in a
//   small FIFO and paces them out as single-cycle coin codes.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   coin_acceptor_if.slave (sensor inputs, accept_en, coin outputs)
//   Parameters:
//     DEBOUNCE    stable synchronised cycles needed to accept a level change (1..255)
//     FIFO_DEPTH  buffered coins (power of 2, >= 2)
//     GAP_CYCLES  forced idle cycles after each emitted code (0..15)
module coin_acceptor #(
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input logic            clk,
   input logic            rst,
   coin_acceptor_if.slave bus
);
   localparam int NUM_LANES = 2;   // lane 0 = five, lane 1 = ten
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE - 1);
   localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

   // ---------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------
   logic [NUM_LANES-1:0] raw, sync1, sync2, lvl, lvl_q, rise;

   assign raw = {bus.coin10_raw, bus.coin5_raw};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         lvl_q <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         lvl_q <= lvl;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [7:0] cnt;
      logic       lvl_r;

      // Counter only runs while the synchronised value disagrees with the
      // debounced level; any return to agreement restarts the count.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt   <= '0;
            lvl_r <= 1'b0;
         end else if (sync2[i] == lvl_r) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            lvl_r <= sync2[i];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end

      assign lvl[i] = lvl_r;
   end

   // ---------------------------------------------------------------
   // Event classification
   // ---------------------------------------------------------------
   logic any_ev, jam, ev_ok, push_try, push, pop, ovf_ev, rej_ev;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          empty, full_c;

   assign rise   = lvl & ~lvl_q;
   assign any_ev = |rise;
   // Current level of the other lane covers both "rose together" and
   // "other already high"; either way the event is one jam.
   assign jam    = (rise[0] & lvl[1]) | (rise[1] & lvl[0]);
   assign ev_ok  = any_ev & ~jam;

   assign empty    = (count == '0);
   assign full_c   = (count == FULL_CNT);
   assign push_try = ev_ok & bus.accept_en;
   // A pop in the same cycle frees a slot, so a full FIFO may still push.
   assign push     = push_try & (~full_c | pop);
   assign ovf_ev   = push_try & full_c & ~pop;
   assign rej_ev   = jam | (ev_ok & ~bus.accept_en) | ovf_ev;

   // ---------------------------------------------------------------
   // Coin FIFO (1 bit per coin: 0 = five, 1 = ten)
   // ---------------------------------------------------------------
   logic [FIFO_DEPTH-1:0] mem;
   logic [AW:0]           count_nx;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= rise[1];
   end

   always_comb begin
      count_nx = count;
      case ({push, pop})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
   end

   // Pointers wrap naturally since FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count_nx;
      end
   end

   // ---------------------------------------------------------------
   // Output scheduler
   // ---------------------------------------------------------------
   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

   state_t     state, state_nx;
   logic [3:0] gap_cnt;
   logic       ready;
   logic [1:0] code_nx;

   // ready: the scheduler may pop this cycle. Besides IDLE, this is the
   // EMIT cycle when no gap is configured and the last GAP cycle, so the
   // code rate is exactly one per (1 + GAP_CYCLES) cycles.
   always_comb begin
      ready = 1'b0;
      case (state)
         S_IDLE:  ready = 1'b1;
         S_EMIT:  ready = (GAP_CYCLES == 0);
         S_GAP:   ready = (gap_cnt == GAP_LAST);
         default: ready = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_nx;
         gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      state_nx = state;
      if (ready && !empty)     state_nx = S_EMIT;
      else if (ready)          state_nx = S_IDLE;
      else if (state == S_EMIT) state_nx = S_GAP;
   end

   always_comb begin
      pop     = ready & ~empty;
      code_nx = 2'b00;
      if (pop) code_nx = mem[rptr] ? 2'b10 : 2'b01;
   end

   // ---------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------
   logic [1:0] code_r;
   logic       reject_r, full_r, ovf_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_r   <= 2'b00;
         reject_r <= 1'b0;
         full_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         code_r   <= code_nx;
         reject_r <= rej_ev;
         full_r   <= (count_nx == FULL_CNT);
         if (ovf_ev) ovf_r <= 1'b1;
      end
   end

   assign bus.coin_code = code_r;
   assign bus.reject    = reject_r;
   assign bus.fifo_full = full_r;
   assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
//   Directed bench for coin_acceptor (DEBOUNCE=4, FIFO_DEPTH=4, GAP_CYCLES=15).
//   Expected coin codes are queued as coins are inserted and checked in order
//   by a monitor as they appear on coin_code.
module tb_coin_acceptor;
   localparam int DEB   = 4;
   localparam int DEPTH = 4;
   localparam int GAP   = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   emit_cnt = 0;
   int   rej_cnt = 0;
   int   last_emit = -1000;
   bit   saw_full = 1'b0;
   logic [1:0] exp_q[$];

   coin_acceptor_if io();

   coin_acceptor #(.DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (io)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: every nonzero code must be the next expected coin and must be
   // at least GAP zero cycles after the previous one.
   always @(negedge clk) begin
      if (rst) begin
         if (io.reject) rej_cnt++;
         if (io.fifo_full) saw_full = 1'b1;
         if (io.coin_code !== 2'b00) begin
            if (exp_q.size() == 0) chk("unexpected_code", 32'(io.coin_code), 0);
            else chk("code_order", 32'(io.coin_code), 32'(exp_q.pop_front()));
            chk("code_gap", 32'(cyc - last_emit >= GAP + 1), 1);
            last_emit = cyc;
            emit_cnt++;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic coin(input bit ten, input int hold);
      if (ten) io.coin10_raw = 1'b1;
      else     io.coin5_raw  = 1'b1;
      cycles(hold);
      io.coin10_raw = 1'b0;
      io.coin5_raw  = 1'b0;
   endtask

   task automatic wait_emits(input int target, input int budget, input string tag);
      int n = 0;
      while (emit_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(emit_cnt), 32'(target));
   endtask

   initial begin
      int t0;
      int n;
      io.coin5_raw  = 1'b0;
      io.coin10_raw = 1'b0;
      io.accept_en  = 1'b1;
      #1 rst = 1'b0;
      cycles(3);
      chk("rst_code",     32'(io.coin_code), 0);
      chk("rst_reject",   32'(io.reject),    0);
      chk("rst_full",     32'(io.fifo_full), 0);
      chk("rst_overflow", 32'(io.overflow),  0);
      rst = 1'b1;
      cycles(3);

      // 1: single five coin, latency DEBOUNCE+3 edges after the first edge
      t0 = cyc;
      exp_q.push_back(2'b01);
      coin(1'b0, 10);
      cycles(20);
      chk("t1_emits",   32'(emit_cnt),  1);
      chk("t1_latency", 32'(last_emit), 32'(t0 + DEB + 4));
      chk("t1_reject",  32'(rej_cnt),   0);

      // 2: short glitch ignored, then a real ten coin
      coin(1'b1, 2);
      cycles(15);
      chk("t2_glitch_emits",  32'(emit_cnt), 1);
      chk("t2_glitch_reject", 32'(rej_cnt),  0);
      exp_q.push_back(2'b10);
      coin(1'b1, 6);
      wait_emits(2, 40, "t2_ten_emit");
      chk("t2_reject", 32'(rej_cnt), 0);

      // 3: both sensors together is a jam
      io.coin5_raw  = 1'b1;
      io.coin10_raw = 1'b1;
      cycles(8);
      io.coin5_raw  = 1'b0;
      io.coin10_raw = 1'b0;
      cycles(30);
      chk("t3_reject", 32'(rej_cnt),      1);
      chk("t3_emits",  32'(emit_cnt),     2);
      chk("t3_full",   32'(io.fifo_full), 0);

      // 4: eight coins every 6 cycles on alternating lines; the pacer drains
      // one per 16 cycles so the eighth finds the FIFO full.
      for (int k = 0; k < 8; k++) begin
         if (k < 7) exp_q.push_back((k % 2 == 1) ? 2'b10 : 2'b01);
         coin(k % 2 == 1, 5);
         cycles(1);
      end
      cycles(10);
      chk("t4_overflow", 32'(io.overflow), 1);
      chk("t4_reject",   32'(rej_cnt),     2);
      chk("t4_saw_full", 32'(saw_full),    1);
      wait_emits(9, 200, "t4_emits");
      cycles(20);
      chk("t4_no_extra",       32'(emit_cnt),      9);
      chk("t4_queue_drained",  32'(exp_q.size()),  0);
      chk("t4_overflow_stays", 32'(io.overflow),   1);
      chk("t4_full_clear",     32'(io.fifo_full),  0);

      // 5: disabled acceptor rejects, re-enabled accepts
      io.accept_en = 1'b0;
      coin(1'b0, 6);
      cycles(12);
      chk("t5_dis_reject", 32'(rej_cnt),  3);
      chk("t5_dis_emits",  32'(emit_cnt), 9);
      io.accept_en = 1'b1;
      exp_q.push_back(2'b01);
      coin(1'b0, 6);
      wait_emits(10, 40, "t5_en_emit");
      chk("t5_en_reject", 32'(rej_cnt), 3);
      cycles(20);

      // 6: reset while a ten is on coin_code with two coins still buffered
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
         coin(k % 2 == 0, 5);
         cycles(1);
      end
      n = 0;
      while (emit_cnt < 12 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t6_two_emitted", 32'(emit_cnt), 12);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (io.coin_code !== 2'b10 && n < 100);
      chk("t6_code_ten", 32'(io.coin_code), 2);
      rst = 1'b0;
      #1;
      chk("t6_rst_code",     32'(io.coin_code), 0);
      chk("t6_rst_reject",   32'(io.reject),    0);
      chk("t6_rst_full",     32'(io.fifo_full), 0);
      chk("t6_rst_overflow", 32'(io.overflow),  0);
      exp_q.delete();
      cycles(3);
      rst = 1'b1;
      cycles(100);
      chk("t6_no_stale_code", 32'(emit_cnt),    13);
      chk("t6_reject",        32'(rej_cnt),     3);
      chk("t6_overflow",      32'(io.overflow), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
